// File: rtl/pll_seq_pkg.sv
// Shared types and DRI field layout for the PLL sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PWRDN,
        ST_WAIT_LOCK,
        ST_RST_HOLD,
        ST_RUN,
        ST_CFG_WR,
        ST_FAIL
    } state_t;

    localparam int DRI_CTRL_W   = 11;
    localparam int DRI_DATA_W   = 33;
    localparam int DRI_ADDR_W   = 9;
    localparam int DRI_WR_BIT   = 0;
    localparam int DRI_RD_BIT   = 1;
    localparam int DRI_ADDR_LSB = 2;
    localparam int DRI_ADDR_MSB = 10;

    // Builds the DRI control word for a single register write.
    function automatic logic [DRI_CTRL_W-1:0] dri_write_ctrl(input logic [DRI_ADDR_W-1:0] addr);
        logic [DRI_CTRL_W-1:0] ctrl;
        ctrl = '0;
        ctrl[DRI_ADDR_MSB:DRI_ADDR_LSB] = addr;
        ctrl[DRI_RD_BIT] = 1'b0;
        ctrl[DRI_WR_BIT] = 1'b1;
        return ctrl;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronises the asynchronous PLL lock and counts consecutive high samples.
module pll_lock_filter #(
    parameter int LOCK_STABLE = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    input  logic clr,
    output logic lock_s,
    output logic lock_stable
);

    localparam int CNT_W = $clog2(LOCK_STABLE + 1);
    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE);

    logic             sync_1;
    logic [CNT_W-1:0] stable_cnt;

    // Two-flop synchroniser for the lock input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_1 <= pll_lock;
            lock_s <= sync_1;
        end
    end

    // Stable counter: saturates at the terminal count, any low sample restarts it.
    always_ff @(posedge clk) begin
        if (reset || clr || !lock_s) begin
            stable_cnt <= '0;
        end else if (stable_cnt != STABLE_TC) begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign lock_stable = (stable_cnt == STABLE_TC);

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL power-up, lock supervision and DRI reconfiguration sequencer.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_PWRDN     | PLL held in power-down for PD_CYCLES
//   ST_WAIT_LOCK | PLL running, waiting for a stable lock (timed)
//   ST_RST_HOLD  | lock stable, fabric reset held a few more cycles
//   ST_RUN       | clocks valid, fabric reset released
//   ST_CFG_WR    | single-cycle DRI write strobe, then relock
//   ST_FAIL      | lock never achieved; sticky until reset
module pll_seq_ctrl
    import pll_seq_pkg::*;
#(
    parameter int PD_CYCLES    = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3,
    parameter int RST_HOLD     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_lock,
    output logic                  pll_powerdown_n,
    output logic [DRI_CTRL_W-1:0] dri_ctrl,
    output logic [DRI_DATA_W-1:0] dri_wdata,
    output logic                  dri_arst_n,
    input  logic                  cfg_req,
    input  logic [DRI_ADDR_W-1:0] cfg_addr,
    input  logic [DRI_DATA_W-1:0] cfg_wdata,
    output logic                  cfg_ack,
    output logic                  cfg_err,
    output logic                  fab_rst,
    output logic                  ready,
    output logic                  fail,
    output logic [1:0]            retry_cnt,
    output logic [7:0]            lock_loss_cnt
);

    localparam int SEQ_MAX = (PD_CYCLES > RST_HOLD) ? PD_CYCLES : RST_HOLD;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);

    // Timers are down-counters reloaded on entry and expiring at zero.
    localparam logic [SEQ_W-1:0] PD_LOAD   = SEQ_W'(PD_CYCLES - 1);
    localparam logic [SEQ_W-1:0] HOLD_LOAD = SEQ_W'(RST_HOLD - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    state_t                state, state_nxt;
    logic [SEQ_W-1:0]      seq_cnt, seq_nxt;
    logic [TMO_W-1:0]      tmo_cnt, tmo_nxt;
    logic [1:0]            retry_nxt;
    logic [7:0]            loss_nxt;
    logic                  ack_nxt, err_nxt;
    logic [DRI_CTRL_W-1:0] ctrl_nxt;
    logic [DRI_DATA_W-1:0] wdata_nxt;
    logic                  lock_s, lock_stable, stable_clr;

    // The stable count must restart from zero after every power-down or DRI write.
    assign stable_clr = (state == ST_PWRDN) || (state == ST_CFG_WR);

    pll_lock_filter #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_filter (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .clr        (stable_clr),
        .lock_s     (lock_s),
        .lock_stable(lock_stable)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        seq_nxt   = seq_cnt;
        tmo_nxt   = tmo_cnt;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        ctrl_nxt  = '0;
        wdata_nxt = '0;
        case (state)
            ST_PWRDN: begin
                tmo_nxt = TMO_LOAD;
                if (seq_cnt == '0) begin
                    state_nxt = ST_WAIT_LOCK;
                end else begin
                    seq_nxt = seq_cnt - 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_stable) begin
                    state_nxt = ST_RST_HOLD;
                    seq_nxt   = HOLD_LOAD;
                end else if (tmo_cnt == '0) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nxt = retry_cnt + 2'd1;
                        state_nxt = ST_PWRDN;
                        seq_nxt   = PD_LOAD;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end else begin
                    tmo_nxt = tmo_cnt - 1'b1;
                end
            end
            ST_RST_HOLD: begin
                // Falling back keeps the timeout running so a flapping lock still times out.
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                end else if (seq_cnt == '0) begin
                    state_nxt = ST_RUN;
                    retry_nxt = 2'd0;
                end else begin
                    seq_nxt = seq_cnt - 1'b1;
                end
            end
            ST_RUN: begin
                // Lock loss wins; a simultaneous request stays pending until the next RUN.
                if (!lock_s) begin
                    state_nxt = ST_PWRDN;
                    seq_nxt   = PD_LOAD;
                    if (lock_loss_cnt != 8'hFF) begin
                        loss_nxt = lock_loss_cnt + 8'd1;
                    end
                end else if (cfg_req && !cfg_ack) begin
                    state_nxt = ST_CFG_WR;
                    ctrl_nxt  = dri_write_ctrl(cfg_addr);
                    wdata_nxt = cfg_wdata;
                    ack_nxt   = 1'b1;
                end
            end
            ST_CFG_WR: begin
                state_nxt = ST_WAIT_LOCK;
                tmo_nxt   = TMO_LOAD;
                retry_nxt = 2'd0;
            end
            ST_FAIL: begin
                if (cfg_req && !cfg_ack) begin
                    ack_nxt = 1'b1;
                    err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_PWRDN;
                seq_nxt   = PD_LOAD;
            end
        endcase
    end

    // State, timers and all outputs registered; level outputs follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_PWRDN;
            seq_cnt         <= PD_LOAD;
            tmo_cnt         <= TMO_LOAD;
            pll_powerdown_n <= 1'b0;
            fab_rst         <= 1'b1;
            ready           <= 1'b0;
            fail            <= 1'b0;
            cfg_ack         <= 1'b0;
            cfg_err         <= 1'b0;
            dri_ctrl        <= '0;
            dri_wdata       <= '0;
            dri_arst_n      <= 1'b0;
            retry_cnt       <= 2'd0;
            lock_loss_cnt   <= 8'd0;
        end else begin
            state           <= state_nxt;
            seq_cnt         <= seq_nxt;
            tmo_cnt         <= tmo_nxt;
            pll_powerdown_n <= !(state_nxt inside {ST_PWRDN, ST_FAIL});
            fab_rst         <= (state_nxt != ST_RUN);
            ready           <= (state_nxt == ST_RUN);
            fail            <= (state_nxt == ST_FAIL);
            cfg_ack         <= ack_nxt;
            cfg_err         <= err_nxt;
            dri_ctrl        <= ctrl_nxt;
            dri_wdata       <= wdata_nxt;
            dri_arst_n      <= 1'b1;
            retry_cnt       <= retry_nxt;
            lock_loss_cnt   <= loss_nxt;
        end
    end

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl with a reduced parameter set.
module tb_pll_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        pll_lock;
    logic        pll_powerdown_n;
    logic [10:0] dri_ctrl;
    logic [32:0] dri_wdata;
    logic        dri_arst_n;
    logic        cfg_req;
    logic [8:0]  cfg_addr;
    logic [32:0] cfg_wdata;
    logic        cfg_ack;
    logic        cfg_err;
    logic        fab_rst;
    logic        ready;
    logic        fail;
    logic [1:0]  retry_cnt;
    logic [7:0]  lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pll_seq_ctrl #(
        .PD_CYCLES   (4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(100),
        .MAX_RETRY   (2),
        .RST_HOLD    (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pll_lock       (pll_lock),
        .pll_powerdown_n(pll_powerdown_n),
        .dri_ctrl       (dri_ctrl),
        .dri_wdata      (dri_wdata),
        .dri_arst_n     (dri_arst_n),
        .cfg_req        (cfg_req),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_ack        (cfg_ack),
        .cfg_err        (cfg_err),
        .fab_rst        (fab_rst),
        .ready          (ready),
        .fail           (fail),
        .retry_cnt      (retry_cnt),
        .lock_loss_cnt  (lock_loss_cnt)
    );

    typedef struct {
        logic rst;
        logic lock;
        logic req;
        logic e_pd_n;
        logic e_fab_rst;
        logic e_ready;
        logic e_arst_n;
        logic e_ack;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks while power-down output stays at lvl; n is the tick count at which it changed.
    task automatic run_len(input logic lvl, input int limit, output int n);
        n = 0;
        while (pll_powerdown_n == lvl && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Ticks until the named output goes high; n = ticks taken (limit+1 if never).
    task automatic wait_ready(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n <= limit);
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cfg_ack && n <= limit);
    endtask

    int  n;
    logic seen;

    initial begin
        reset     = 1'b1;
        pll_lock  = 1'b0;
        cfg_req   = 1'b0;
        cfg_addr  = 9'h000;
        cfg_wdata = 33'h0;

        //            rst lock req  pd  frst rdy arst ack
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset values and the initial power-down pulse.
        for (int i = 0; i < 8; i++) begin
            reset    = vecs[i].rst;
            pll_lock = vecs[i].lock;
            cfg_req  = vecs[i].req;
            tick();
            check($sformatf("row%0d_pd_n", i), pll_powerdown_n, vecs[i].e_pd_n);
            check($sformatf("row%0d_fab_rst", i), fab_rst, vecs[i].e_fab_rst);
            check($sformatf("row%0d_ready", i), ready, vecs[i].e_ready);
            check($sformatf("row%0d_arst_n", i), dri_arst_n, vecs[i].e_arst_n);
            check($sformatf("row%0d_ack", i), cfg_ack, vecs[i].e_ack);
            if (i == 0) begin
                check("rst_fail", fail, 1'b0);
                check("rst_err", cfg_err, 1'b0);
                check("rst_dri_ctrl", dri_ctrl, 11'h0);
                check("rst_dri_wdata", dri_wdata, 33'h0);
                check("rst_retry", retry_cnt, 2'd0);
                check("rst_loss", lock_loss_cnt, 8'd0);
            end
        end

        // Bring-up: lock 10 cycles after power-down released, READY 14 cycles later.
        for (int i = 0; i < 8; i++) tick();
        pll_lock = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (ready || !fab_rst) seen = 1'b1;
        end
        check("bringup_ready_early", seen, 1'b0);
        tick();
        check("bringup_ready", ready, 1'b1);
        check("bringup_fab_rst", fab_rst, 1'b0);
        check("bringup_pd_n", pll_powerdown_n, 1'b1);

        // Lock loss in RUN with a request raised as the loss is acted on.
        tick();
        tick();
        pll_lock = 1'b0;
        tick();
        tick();
        check("loss_ready_still", ready, 1'b1);
        cfg_req   = 1'b1;
        cfg_addr  = 9'h01A;
        cfg_wdata = 33'h17;
        tick();
        check("loss_fab_rst", fab_rst, 1'b1);
        check("loss_ready", ready, 1'b0);
        check("loss_ack", cfg_ack, 1'b0);
        check("loss_cnt1", lock_loss_cnt, 8'd1);
        check("loss_pd_n", pll_powerdown_n, 1'b0);
        run_len(1'b0, 20, n);
        check("loss_pd_len", n, 4);
        pll_lock = 1'b1;
        wait_ack(40, n);
        check("pending_ack_lat", n, 15);

        // Reconfiguration write strobe.
        check("cfg_dri_ctrl", dri_ctrl, 11'h069);
        check("cfg_dri_wdata", dri_wdata, 33'h17);
        check("cfg_err0", cfg_err, 1'b0);
        check("cfg_fab_rst", fab_rst, 1'b1);
        check("cfg_ready", ready, 1'b0);
        cfg_req  = 1'b0;
        pll_lock = 1'b0;
        tick();
        check("cfg_ctrl_clr", dri_ctrl, 11'h0);
        check("cfg_wdata_clr", dri_wdata, 33'h0);
        check("cfg_ack_clr", cfg_ack, 1'b0);
        check("cfg_fab_rst2", fab_rst, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        pll_lock = 1'b1;
        wait_ready(40, n);
        check("cfg_relock_lat", n, 14);

        // Second loss, then reset in WAIT_LOCK.
        pll_lock = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("loss_cnt2", lock_loss_cnt, 8'd2);
        run_len(1'b0, 20, n);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        check("rstwl_pd_n", pll_powerdown_n, 1'b0);
        check("rstwl_fab_rst", fab_rst, 1'b1);
        check("rstwl_loss", lock_loss_cnt, 8'd0);
        check("rstwl_arst_n", dri_arst_n, 1'b0);

        // Glitchy lock: READY 14 cycles after the final rising edge.
        reset = 1'b0;
        run_len(1'b0, 20, n);
        pll_lock = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_ready(40, n);
        check("glitch_ready_lat", n, 14);

        // No lock: two retries, then FAIL.
        pll_lock = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        run_len(1'b0, 20, n);
        check("nolock_pd0", n, 4);
        run_len(1'b1, 200, n);
        check("nolock_tmo1", n, 100);
        check("nolock_retry1", retry_cnt, 2'd1);
        run_len(1'b0, 20, n);
        check("nolock_pd1", n, 4);
        run_len(1'b1, 200, n);
        check("nolock_tmo2", n, 100);
        check("nolock_retry2", retry_cnt, 2'd2);
        run_len(1'b0, 20, n);
        check("nolock_pd2", n, 4);
        run_len(1'b1, 200, n);
        check("nolock_tmo3", n, 100);
        check("nolock_fail", fail, 1'b1);
        check("nolock_fail_pd_n", pll_powerdown_n, 1'b0);
        check("nolock_fail_fab_rst", fab_rst, 1'b1);

        // Request in FAIL: one ack with error, no re-ack while still held.
        cfg_req = 1'b1;
        tick();
        check("fail_ack", cfg_ack, 1'b1);
        check("fail_err", cfg_err, 1'b1);
        tick();
        check("fail_no_reack", cfg_ack, 1'b0);
        cfg_req = 1'b0;
        tick();
        check("fail_sticky", fail, 1'b1);

        // Reset in FAIL.
        reset = 1'b1;
        tick();
        check("rstf_fail", fail, 1'b0);
        check("rstf_pd_n", pll_powerdown_n, 1'b0);
        check("rstf_retry", retry_cnt, 2'd0);
        check("rstf_loss", lock_loss_cnt, 8'd0);
        check("rstf_ready", ready, 1'b0);
        check("rstf_err", cfg_err, 1'b0);
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
